// File: rtl/full_st0_phase_seq_pkg.sv
// Shared stage types: state encoding, default geometry and field widths.
// No logic; constants and types only.
// No flow control of its own.
package full_st0_phase_seq_pkg;

    localparam int NUM_TAPS_DEF   = 12;
    localparam int PIPE_LAT_DEF   = 5;
    localparam int ERR_PHASES_DEF = 4;

    localparam int TAP_W   = 4;   // tap counter / tap_address width
    localparam int ADDR_W  = 7;   // data memory address width
    localparam int DRN_W   = 4;   // drain counter width
    localparam int PHASE_W = 2;   // error phase width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ERR   = 3'd3,
        ST_UPD   = 3'd4
    } state_t;

endpackage

// File: rtl/full_st0_phase_cnt.sv
// Loadable wrap counter: counts 0..i_max with enable, wraps to 0, flags terminal count.
// Count updates one cycle after i_en/i_load; o_tc is combinational from the count.
// No backpressure; the owner gates i_en.
module full_st0_phase_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting; wrap back to zero at the terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= (r_count == i_max) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_max);

endmodule

// File: rtl/full_st0_phase_seq.sv
// Stage-0 phase sequencer: forward tap sweep, pipeline drain, error collection, tap update sweep.
// Addresses are combinational from state/counters; update_done is registered (first IDLE cycle).
// out_rdy low freezes the forward sweep; the update sweep never stalls.
module full_st0_phase_seq
    import full_st0_phase_seq_pkg::*;
#(
    parameter int NUM_TAPS   = NUM_TAPS_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int ERR_PHASES = ERR_PHASES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  data_base,
    input  logic               out_rdy,
    input  logic               error_valid,
    input  logic               error_last,
    output logic               busy,
    output logic               active,
    output logic               active_start,
    output logic [TAP_W-1:0]   tap_address,
    output logic [ADDR_W-1:0]  data_read_addr,
    output logic [PHASE_W-1:0] error_phase,
    output logic               error_tap_update,
    output logic               update_done
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic                r_fwd_first;
    logic                r_update_done;

    logic                w_tap_load, w_tap_en, w_tap_tc;
    logic [TAP_W-1:0]    w_tap_cnt;
    logic                w_drn_load, w_drn_en, w_drn_tc;
    logic [DRN_W-1:0]    w_drn_cnt;
    logic                w_ph_load, w_ph_en, w_ph_tc;
    logic [PHASE_W-1:0]  w_ph_cnt;

    // Shared by the forward and update sweeps; wraps to 0 after the last tap.
    full_st0_phase_cnt #(.WIDTH(TAP_W)) u_tap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tap_load),
        .i_load_val ('0),
        .i_en       (w_tap_en),
        .i_max      (TAP_W'(NUM_TAPS - 1)),
        .o_count    (w_tap_cnt),
        .o_tc       (w_tap_tc)
    );

    full_st0_phase_cnt #(.WIDTH(DRN_W)) u_drn_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_drn_load),
        .i_load_val ('0),
        .i_en       (w_drn_en),
        .i_max      (DRN_W'(PIPE_LAT - 1)),
        .o_count    (w_drn_cnt),
        .o_tc       (w_drn_tc)
    );

    full_st0_phase_cnt #(.WIDTH(PHASE_W)) u_ph_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_ph_load),
        .i_load_val ('0),
        .i_en       (w_ph_en),
        .i_max      (PHASE_W'(ERR_PHASES - 1)),
        .o_count    (w_ph_cnt),
        .o_tc       (w_ph_tc)
    );

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Base latch and one-cycle flags for active_start and update_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base        <= '0;
            r_fwd_first   <= 1'b0;
            r_update_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_base <= data_base;
            end
            r_fwd_first   <= (r_state == ST_IDLE) && start;
            r_update_done <= (r_state == ST_UPD) && w_tap_tc;
        end
    end

    // Next-state, counter control and per-state outputs; unowned outputs stay 0.
    always_comb begin
        w_next           = r_state;
        w_tap_load       = 1'b0;
        w_tap_en         = 1'b0;
        w_drn_load       = 1'b0;
        w_drn_en         = 1'b0;
        w_ph_load        = 1'b0;
        w_ph_en          = 1'b0;
        active           = 1'b0;
        active_start     = 1'b0;
        tap_address      = '0;
        data_read_addr   = '0;
        error_phase      = '0;
        error_tap_update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_FWD;
                    w_tap_load = 1'b1;
                end
            end
            ST_FWD: begin
                active         = out_rdy;
                active_start   = r_fwd_first;
                tap_address    = w_tap_cnt;
                data_read_addr = r_base + {{(ADDR_W - TAP_W){1'b0}}, w_tap_cnt};
                w_tap_en       = out_rdy;
                if (out_rdy && w_tap_tc) begin
                    w_next     = ST_DRAIN;
                    w_drn_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_drn_en = 1'b1;
                if (w_drn_tc) begin
                    w_next    = ST_ERR;
                    w_ph_load = 1'b1;
                end
            end
            ST_ERR: begin
                error_phase = w_ph_cnt;
                w_ph_en     = error_valid;
                if (error_valid && error_last) begin
                    w_next     = ST_UPD;
                    w_tap_load = 1'b1;
                end
            end
            ST_UPD: begin
                error_tap_update = 1'b1;
                tap_address      = w_tap_cnt;
                w_tap_en         = 1'b1;
                if (w_tap_tc) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != ST_IDLE);
    assign update_done = r_update_done;

endmodule

// File: tb/tb_full_st0_phase_seq.sv
// Randomized bench for full_st0_phase_seq with a pass-level expectation model.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
// Stalls, stray starts, ignored error strobes and reset mid-pass are exercised.
module tb_full_st0_phase_seq;

    localparam int NT = 12;
    localparam int PL = 5;
    localparam int EP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] data_base;
    logic       out_rdy;
    logic       error_valid;
    logic       error_last;
    logic       busy;
    logic       active;
    logic       active_start;
    logic [3:0] tap_address;
    logic [6:0] data_read_addr;
    logic [1:0] error_phase;
    logic       error_tap_update;
    logic       update_done;

    int n_chk  = 0;
    int n_fail = 0;

    full_st0_phase_seq #(
        .NUM_TAPS   (NT),
        .PIPE_LAT   (PL),
        .ERR_PHASES (EP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .data_base        (data_base),
        .out_rdy          (out_rdy),
        .error_valid      (error_valid),
        .error_last       (error_last),
        .busy             (busy),
        .active           (active),
        .active_start     (active_start),
        .tap_address      (tap_address),
        .data_read_addr   (data_read_addr),
        .error_phase      (error_phase),
        .error_tap_update (error_tap_update),
        .update_done      (update_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int e_busy, input int e_act,
                            input int e_ast, input int e_tap, input int e_dra,
                            input int e_ph, input int e_etu, input int e_done);
        chk({tag, ".busy"},   int'(busy),             e_busy);
        chk({tag, ".active"}, int'(active),           e_act);
        chk({tag, ".astart"}, int'(active_start),     e_ast);
        chk({tag, ".tap"},    int'(tap_address),      e_tap);
        chk({tag, ".daddr"},  int'(data_read_addr),   e_dra);
        chk({tag, ".phase"},  int'(error_phase),      e_ph);
        chk({tag, ".etu"},    int'(error_tap_update), e_etu);
        chk({tag, ".done"},   int'(update_done),      e_done);
    endtask

    // One complete pass. stall_mode: 0 none, 1 three-cycle stall at tap 5, 2 random.
    task automatic run_pass(input logic [6:0] base, input int stall_mode,
                            input int n_err, input bit rst_drain);
        int k, cyc, nact, stalls, nv;
        bit rdy, v;
        k = 0; cyc = 0; nact = 0; stalls = 0; nv = 0;

        start = 1'b1; data_base = base; out_rdy = 1'($urandom);
        error_valid = 1'($urandom); error_last = 1'($urandom);
        #1;
        chk_outs("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Forward sweep: address = base + tap mod 128, advancing only when ready.
        while (k < NT && cyc < 500) begin
            if (stall_mode == 0) begin
                rdy = 1'b1;
            end else if (stall_mode == 1) begin
                rdy = !(k == 5 && stalls < 3);
                if (!rdy) stalls++;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            out_rdy = rdy; start = 1'($urandom); data_base = 7'($urandom);
            error_valid = 1'($urandom); error_last = 1'($urandom);
            #1;
            chk_outs("fwd", 1, int'(rdy), (cyc == 0) ? 1 : 0, k,
                     (int'(base) + k) % 128, 0, 0, 0);
            nact += int'(active);
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        chk("fwd.nact", nact, NT);

        // Drain: fixed length, error strobes ignored.
        for (int i = 0; i < PL; i++) begin
            out_rdy = 1'($urandom); start = 1'($urandom);
            error_valid = 1'($urandom); error_last = 1'($urandom);
            if (rst_drain && i == 2) begin
                reset = 1'b1; start = 1'b1;
            end
            #1;
            chk_outs("drain", 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (rst_drain && i == 2) begin
                reset = 1'b0; start = 1'b0;
                #1;
                chk_outs("rst", 0, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                #1;
                chk_outs("rst2", 0, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                return;
            end
        end

        // Error collection: phase = accepted samples so far mod EP.
        while (nv < n_err) begin
            v = ($urandom_range(0, 2) != 0);
            error_valid = v;
            error_last  = v ? (nv == n_err - 1) : 1'($urandom);
            out_rdy = 1'($urandom); start = 1'($urandom);
            #1;
            chk_outs("err", 1, 0, 0, 0, 0, nv % EP, 0, 0);
            if (v) nv++;
            @(negedge clk);
        end
        error_valid = 1'b0; error_last = 1'b0;

        // Update sweep: one tap per cycle regardless of out_rdy or start.
        for (int i = 0; i < NT; i++) begin
            start = 1'($urandom); data_base = 7'($urandom); out_rdy = 1'($urandom);
            #1;
            chk_outs("upd", 1, 0, 0, i, 0, 0, 1, 0);
            @(negedge clk);
        end

        start = 1'b0;
        #1;
        chk_outs("done", 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; data_base = 7'd99; out_rdy = 1'b1;
        error_valid = 1'b0; error_last = 1'b0;
        @(negedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        chk_outs("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        run_pass(7'd10,  0, 5, 1'b0);
        run_pass(7'd124, 0, 3, 1'b0);
        run_pass(7'd51,  1, 5, 1'b0);
        run_pass(7'd20,  0, 2, 1'b1);
        run_pass(7'd55,  0, 1, 1'b0);
        for (int p = 0; p < 8; p++) begin
            run_pass(7'($urandom), 2, $urandom_range(1, 9), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/full_st0_phase_seq.md
FULL_ST0_PHASE_SEQ -- requirements
Module: full_st0_phase_seq

Interface
REQ-001 Parameter NUM_TAPS, default 12, taps per forward pass (2..16).
REQ-002 Parameter PIPE_LAT, default 5, datapath drain latency in cycles (1..15).
REQ-003 Parameter ERR_PHASES, default 4, error phases per update (power of two, max 4).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a stage pass.
REQ-007 data_base  input  7  data memory base read address, sampled with start.
REQ-008 out_rdy  input  1  downstream ready; low stalls the forward sweep.
REQ-009 error_valid  input  1  one error sample accepted this cycle.
REQ-010 error_last  input  1  qualifies error_valid as final sample of pass.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 active  output  1  forward tap read issued this cycle.
REQ-013 active_start  output  1  one-cycle pulse on first cycle of FWD.
REQ-014 tap_address  output  4  tap/bias memory read address.
REQ-015 data_read_addr  output  7  data memory read address.
REQ-016 error_phase  output  2  current error phase index.
REQ-017 error_tap_update  output  1  tap write-back sweep in progress.
REQ-018 update_done  output  1  one-cycle pulse at end of UPD.

Function
REQ-019 States SHALL be IDLE, FWD, DRAIN, ERR, UPD; one-hot or binary, implementer's choice.
REQ-020 IDLE: start=1 -> FWD next cycle; data_base latched; tap counter cleared.
REQ-021 start in any state other than IDLE SHALL be ignored (no latch, no restart).
REQ-022 active_start SHALL be 1 exactly on the first FWD cycle, independent of out_rdy.
REQ-023 FWD: tap_address = tap counter; data_read_addr = latched base + tap counter, mod 128 (wraps 127 -> 0).
REQ-024 FWD: active = out_rdy; counter increments only when out_rdy=1; out_rdy=0 holds all addresses.
REQ-025 FWD: out_rdy=1 with counter = NUM_TAPS-1 -> DRAIN; exactly NUM_TAPS active cycles per pass.
REQ-026 DRAIN: remains PIPE_LAT cycles (counter), then -> ERR; active=0; error_valid ignored.
REQ-027 ERR: each error_valid increments error_phase mod ERR_PHASES; error_phase cleared on ERR entry.
REQ-028 ERR: error_valid & error_last -> UPD; error_last without error_valid ignored.
REQ-029 UPD: tap_address sweeps 0..NUM_TAPS-1, one per cycle, no stall; error_tap_update=1 throughout.
REQ-030 UPD: after address NUM_TAPS-1, update_done=1 for one cycle concurrently with return to IDLE.
REQ-031 Outputs not owned by the current state SHALL be 0 (tap_address, data_read_addr included).

Reset
REQ-032 reset SHALL force IDLE and all outputs and counters to 0 on the next edge, in any state, overriding start.
REQ-033 start sampled in the same cycle as reset SHALL be discarded.

Structure
REQ-034 State encoding enum and NUM_TAPS/PIPE_LAT defaults SHALL reside in the shared stage types package.
REQ-035 A sub-module full_st0_phase_cnt (loadable wrap counter with enable and terminal-count flag) SHALL be instantiated for tap, drain and phase counters.

Verification
REQ-036 start, data_base=7'd10, out_rdy=1 -> active 12 cycles, data_read_addr 10..21, active_start on cycle 1 only.
REQ-037 data_base=7'd124 -> data_read_addr 124,125,126,127,0..7.
REQ-038 out_rdy low 3 cycles mid-sweep at tap 5 -> tap_address holds 5, active=0, total active count still 12.
REQ-039 5 error_valid, last with error_last -> error_phase 0,1,2,3,0; UPD entered; 12 sweep cycles then update_done pulse; busy drops.
REQ-040 reset asserted in DRAIN, and start during UPD -> IDLE with all outputs 0; mid-UPD start has no effect.
